// File: rtl/bram_delay_line.sv
// Fixed-depth delay line built on a circular read-first block RAM shared by all channels.
// Define BRAM_DELAY_FLUSH_EN to add the synchronous flush input.
module bram_delay_line #(
    parameter int unsigned DEPTH    = 514,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 1
) (
    input  logic                      ap_clk,
    input  logic                      reset_n,
`ifdef BRAM_DELAY_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic [ADDR_W:0]           fill_count
);
    localparam int unsigned       DW       = CHANNELS * WIDTH;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic              clear;
    logic              accept;
    logic              full;

`ifdef BRAM_DELAY_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign accept = in_valid && reset_n && !clear;
    assign full   = (fill_count == FILL_MAX);

    // Array has no reset so it maps onto block RAM; stale words are masked until full.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            mem[ptr] <= in_data;
        end
    end

    // Read-first: the word at ptr was written DEPTH accepted beats ago.
    always_ff @(posedge ap_clk) begin
        if (!reset_n || clear) begin
            ptr        <= '0;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (in_valid) begin
            out_data  <= full ? mem[ptr] : '0;
            out_valid <= full;
            ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            if (!full) begin
                fill_count <= fill_count + 1'b1;
            end
        end
    end
endmodule
